// File: rtl/door_idol_rect_ctrl.sv
// door_idol_rect_ctrl: hit test, offsets and door/idol game state for one
// 32x32 tile. Optional idol blink when DOOR_IDOL_BLINK_EN is defined.
//
// Ports:
//   clk, resetN            clock, async active-low reset
//   pixelX, pixelY         current VGA pixel (11b)
//   startOfFrame           frame pulse; latches topLeftX/Y, steps state
//   topLeftX, topLeftY     requested object position (11b)
//   brickDestroyed         pulse: door uncovered
//   enemiesCleared         pulse: idol released
//   playerHit              level: player touches object
//   InsideRectangle        pixel inside visible object (1 clk latency)
//   offsetX, offsetY       pixel - latched top-left, 0 when outside
//   select                 bitmap select, 0 door / 1 idol
//   idolCollected          1-clk pulse on pickup
//   levelDone              sticky after pickup until reset
module door_idol_rect_ctrl #(
    parameter int OBJ_BITS     = 5,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        brickDestroyed,
    input  logic        enemiesCleared,
    input  logic        playerHit,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        select,
    output logic        idolCollected,
    output logic        levelDone
);

    localparam logic [11:0] OBJ_SIZE = 12'(1 << OBJ_BITS);

    typedef enum logic [1:0] {
        HIDDEN,
        DOOR,
        IDOL,
        COLLECTED
    } state_t;

    state_t      state;
    logic [10:0] tl_x;
    logic [10:0] tl_y;
    logic        pend_brick;
    logic        pend_enemies;

    logic [11:0] end_x;
    logic [11:0] end_y;
    logic        in_x;
    logic        in_y;
    logic        visible;
    logic        blank;
    logic        hit;
    logic        take_brick;
    logic        take_enemies;
    logic        events_on;

`ifdef DOOR_IDOL_BLINK_EN
    logic [4:0] frame_cnt;

    // Odd blocks of BLINK_FRAMES frames are the "off" half of the blink.
    always_comb begin
        blank = (state == IDOL) &&
                (((int'(frame_cnt) / BLINK_FRAMES) % 2) != 0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            frame_cnt <= '0;
        else if (state != IDOL)
            frame_cnt <= '0;
        else if (startOfFrame)
            frame_cnt <= frame_cnt + 5'd1;
    end
`else
    // Steady idol: never blanked.
    always_comb begin
        blank = (BLINK_FRAMES < 0);
    end
`endif

    // 12-bit compare so tl+32 past 2047 clips instead of wrapping.
    always_comb begin
        end_x        = {1'b0, tl_x} + OBJ_SIZE;
        end_y        = {1'b0, tl_y} + OBJ_SIZE;
        in_x         = ({1'b0, pixelX} >= {1'b0, tl_x}) &&
                       ({1'b0, pixelX} < end_x);
        in_y         = ({1'b0, pixelY} >= {1'b0, tl_y}) &&
                       ({1'b0, pixelY} < end_y);
        visible      = (state == DOOR) || (state == IDOL);
        hit          = in_x && in_y && visible && !blank;
        take_brick   = startOfFrame && (state == HIDDEN) && pend_brick;
        take_enemies = startOfFrame && (state == DOOR) && pend_enemies;
        events_on    = (state != COLLECTED);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= HIDDEN;
            tl_x            <= '0;
            tl_y            <= '0;
            pend_brick      <= 1'b0;
            pend_enemies    <= 1'b0;
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            select          <= 1'b0;
            idolCollected   <= 1'b0;
            levelDone       <= 1'b0;
        end else begin
            if (startOfFrame) begin
                tl_x <= topLeftX;
                tl_y <= topLeftY;
            end

            InsideRectangle <= hit;
            offsetX         <= hit ? pixelX - tl_x : '0;
            offsetY         <= hit ? pixelY - tl_y : '0;
            select          <= (state == IDOL);
            idolCollected   <= 1'b0;

            // A pulse landing on the consuming frame edge re-arms the flag.
            pend_brick   <= (pend_brick & ~take_brick) |
                            (brickDestroyed & events_on);
            pend_enemies <= (pend_enemies & ~take_enemies) |
                            (enemiesCleared & events_on);

            unique case (state)
                HIDDEN: if (take_brick) state <= DOOR;
                DOOR:   if (take_enemies) state <= IDOL;
                IDOL: begin
                    if (playerHit) begin
                        state         <= COLLECTED;
                        idolCollected <= 1'b1;
                        levelDone     <= 1'b1;
                    end
                end
                COLLECTED: state <= COLLECTED;
            endcase
        end
    end

endmodule

// File: tb/tb_door_idol_rect_ctrl.sv
// tb_door_idol_rect_ctrl: directed bench for door_idol_rect_ctrl.
// Define DOOR_IDOL_BLINK_EN for the blink scenario.
module tb_door_idol_rect_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
    logic        startOfFrame, brickDestroyed, enemiesCleared, playerHit;
    logic        InsideRectangle, select, idolCollected, levelDone;
    logic [10:0] offsetX, offsetY;

    int checks = 0;
    int errors = 0;

    door_idol_rect_ctrl dut (
        .clk(clk), .resetN(resetN),
        .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .brickDestroyed(brickDestroyed),
        .enemiesCleared(enemiesCleared),
        .playerHit(playerHit),
        .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY),
        .select(select),
        .idolCollected(idolCollected),
        .levelDone(levelDone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic px(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        tick();
        resetN = 1'b1;
    endtask

    // Reaches DOOR at tl=(x,y), optionally IDOL as well.
    task automatic go_state(input int x, input int y, input bit idol);
        topLeftX = 11'(x);
        topLeftY = 11'(y);
        brickDestroyed = 1'b1;
        enemiesCleared = idol;
        tick();
        brickDestroyed = 1'b0;
        enemiesCleared = 1'b0;
        sof();
        if (idol) sof();
    endtask

    task automatic test_reset();
        startOfFrame = 0; brickDestroyed = 0;
        enemiesCleared = 0; playerHit = 0;
        pixelX = 0; pixelY = 0; topLeftX = 0; topLeftY = 0;
        resetN = 1'b0;
        tick();
        tick();
        checks++;
        if ({InsideRectangle, offsetX, offsetY, select,
             idolCollected, levelDone} !== 25'd0)
            begin errors++; $display("FAIL reset: outs=%h req=0",
                {InsideRectangle, offsetX, offsetY, select,
                 idolCollected, levelDone}); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_door();
        topLeftX = 100; topLeftY = 50;
        sof();
        px(110, 60);
        checks++;
        if (InsideRectangle !== 1'b0)
            begin errors++; $display("FAIL hidden_inv: ins=%b req=0",
                InsideRectangle); end
        brickDestroyed = 1'b1;
        tick();
        brickDestroyed = 1'b0;
        sof();
        px(110, 60);
        checks++;
        if ({InsideRectangle, offsetX, offsetY, select} !==
            {1'b1, 11'd10, 11'd10, 1'b0})
            begin errors++; $display("FAIL door_hit: ins=%b ox=%0d oy=%0d sel=%b req 1 10 10 0",
                InsideRectangle, offsetX, offsetY, select); end
    endtask

    task automatic test_edges();
        int xs[5] = '{132, 99, 131, 100, 100};
        int ys[5] = '{50, 50, 81, 50, 82};
        bit ei[5] = '{0, 0, 1, 1, 0};
        int eo[5] = '{0, 0, 31, 0, 0};
        for (int i = 0; i < 5; i++) begin
            px(xs[i], ys[i]);
            checks++;
            if ({InsideRectangle, offsetX, offsetY} !==
                {ei[i], 11'(eo[i]), 11'(eo[i])})
                begin errors++; $display("FAIL edge%0d: ins=%b ox=%0d oy=%0d req %b %0d %0d",
                    i, InsideRectangle, offsetX, offsetY,
                    ei[i], eo[i], eo[i]); end
        end
        playerHit = 1'b1;
        px(110, 60);
        playerHit = 1'b0;
        checks++;
        if ({idolCollected, levelDone, InsideRectangle} !== 3'b001)
            begin errors++; $display("FAIL door_hit_ignored: col=%b done=%b ins=%b req 0 0 1",
                idolCollected, levelDone, InsideRectangle); end
    endtask

    task automatic test_sof_pulse();
        do_reset();
        topLeftX = 100; topLeftY = 50;
        brickDestroyed = 1'b1;
        sof();
        brickDestroyed = 1'b0;
        px(110, 60);
        checks++;
        if (InsideRectangle !== 1'b0)
            begin errors++; $display("FAIL sof_pulse_defer: ins=%b req=0",
                InsideRectangle); end
        sof();
        px(110, 60);
        checks++;
        if (InsideRectangle !== 1'b1)
            begin errors++; $display("FAIL sof_pulse_apply: ins=%b req=1",
                InsideRectangle); end
    endtask

    task automatic test_idol();
        do_reset();
        topLeftX = 100; topLeftY = 50;
        brickDestroyed = 1'b1;
        enemiesCleared = 1'b1;
        tick();
        brickDestroyed = 1'b0;
        enemiesCleared = 1'b0;
        sof();
        px(110, 60);
        checks++;
        if ({InsideRectangle, select} !== 2'b10)
            begin errors++; $display("FAIL both_first: ins=%b sel=%b req 1 0",
                InsideRectangle, select); end
        sof();
        px(110, 60);
        checks++;
        if ({InsideRectangle, select} !== 2'b11)
            begin errors++; $display("FAIL both_second: ins=%b sel=%b req 1 1",
                InsideRectangle, select); end
    endtask

    task automatic test_collect();
        playerHit = 1'b1;
        px(110, 60);
        playerHit = 1'b0;
        checks++;
        if ({idolCollected, levelDone} !== 2'b11)
            begin errors++; $display("FAIL collect_pulse: col=%b done=%b req 1 1",
                idolCollected, levelDone); end
        px(110, 60);
        checks++;
        if ({idolCollected, levelDone, InsideRectangle, offsetX} !==
            {3'b010, 11'd0})
            begin errors++; $display("FAIL collect_after: col=%b done=%b ins=%b ox=%0d req 0 1 0 0",
                idolCollected, levelDone, InsideRectangle, offsetX); end
        brickDestroyed = 1'b1;
        enemiesCleared = 1'b1;
        playerHit = 1'b1;
        sof();
        brickDestroyed = 1'b0;
        enemiesCleared = 1'b0;
        sof();
        playerHit = 1'b0;
        px(110, 60);
        checks++;
        if ({idolCollected, levelDone, InsideRectangle} !== 3'b010)
            begin errors++; $display("FAIL collected_terminal: col=%b done=%b ins=%b req 0 1 0",
                idolCollected, levelDone, InsideRectangle); end
    endtask

    task automatic test_clip();
        do_reset();
        go_state(2030, 470, 1'b0);
        px(2047, 471);
        checks++;
        if ({InsideRectangle, offsetX, offsetY} !==
            {1'b1, 11'd17, 11'd1})
            begin errors++; $display("FAIL clip_edge: ins=%b ox=%0d oy=%0d req 1 17 1",
                InsideRectangle, offsetX, offsetY); end
        px(0, 471);
        checks++;
        if ({InsideRectangle, offsetX, offsetY} !== 23'd0)
            begin errors++; $display("FAIL clip_nowrap: ins=%b ox=%0d oy=%0d req 0 0 0",
                InsideRectangle, offsetX, offsetY); end
    endtask

    task automatic test_blink();
        bit exp;
        do_reset();
        go_state(100, 50, 1'b1);
        for (int f = 0; f < 34; f++) begin
`ifdef DOOR_IDOL_BLINK_EN
            exp = ((f % 32) < 16);
`else
            exp = 1'b1;
`endif
            px(110, 60);
            checks++;
            if (InsideRectangle !== exp)
                begin errors++; $display("FAIL blink_f%0d: ins=%b req=%b",
                    f, InsideRectangle, exp); end
            sof();
        end
    endtask

    task automatic test_reset_mid();
        pixelX = 110; pixelY = 60;
        resetN = 1'b0;
        #1;
        checks++;
        if ({InsideRectangle, select, levelDone} !== 3'b000)
            begin errors++; $display("FAIL reset_async: ins=%b sel=%b done=%b req 0 0 0",
                InsideRectangle, select, levelDone); end
        tick();
        resetN = 1'b1;
        topLeftX = 100; topLeftY = 50;
        sof();
        sof();
        px(110, 60);
        checks++;
        if ({InsideRectangle, select, levelDone} !== 3'b000)
            begin errors++; $display("FAIL reset_hidden: ins=%b sel=%b done=%b req 0 0 0",
                InsideRectangle, select, levelDone); end
    endtask

    initial begin
        test_reset();
        test_door();
        test_edges();
        test_sof_pulse();
        test_idol();
        test_collect();
        test_clip();
        test_blink();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
            checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not complete");
        $fatal(1);
    end

endmodule
